// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and gray/binary helpers for read and write sides
package fifo_pkg;

  localparam int ADDR_SIZE = 3;
  localparam int DEPTH     = 2 ** ADDR_SIZE;
  localparam int PTR_W     = ADDR_SIZE + 1;

  // Helpers work on a 32-bit container so any pointer width up to 32 can use them.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_level_block_if.sv
// rtl/read_level_block_if.sv - read-side FIFO control bus between the read logic and its user
interface read_level_block_if #(parameter int addr_size = 3);

  logic                 read_inc_i;
  logic [addr_size:0]   write_to_read_pointer_i;
  logic [addr_size:0]   almost_empty_threshold_i;
  logic                 read_underflow_clear_i;
  logic [addr_size-1:0] read_address_o;
  logic [addr_size:0]   read_pointer_o;
  logic [addr_size:0]   read_level_o;
  logic                 read_empty_o;
  logic                 read_almost_empty_o;
  logic                 read_underflow_o;

  modport master (
    output read_inc_i, write_to_read_pointer_i, almost_empty_threshold_i, read_underflow_clear_i,
    input  read_address_o, read_pointer_o, read_level_o, read_empty_o, read_almost_empty_o,
           read_underflow_o
  );

  modport slave (
    input  read_inc_i, write_to_read_pointer_i, almost_empty_threshold_i, read_underflow_clear_i,
    output read_address_o, read_pointer_o, read_level_o, read_empty_o, read_almost_empty_o,
           read_underflow_o
  );

endinterface

// File: rtl/read_level_block_gray_to_binary.sv
// rtl/read_level_block_gray_to_binary.sv - parametrised XOR-prefix gray to binary converter
module gray_to_binary #(
  parameter int width = 4
) (
  input  logic [width-1:0] gray_i,
  output logic [width-1:0] binary_o
);

  always_comb begin
    binary_o = gray_i;
    for (int i = width - 2; i >= 0; i--) begin
      binary_o[i] = binary_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/read_level_block.sv
// rtl/read_level_block.sv - async FIFO read-side pointers, level and flags
// Optional READ_PTR_SYNC_EN: internal two-flop synchroniser on the incoming write pointer.
module read_level_block
  import fifo_pkg::*;
#(
  parameter int addr_size = 3
) (
  input logic               read_clock_i,
  input logic               read_reset_i,
  read_level_block_if.slave bus
);

  localparam int pw = addr_size + 1;

  logic [pw-1:0] write_gray;
  logic [pw-1:0] write_binary;
  logic [pw-1:0] read_binary_q;
  logic [pw-1:0] read_gray_q;
  logic [pw-1:0] read_binary_next;
  logic [pw-1:0] read_gray_next;
  logic [pw-1:0] level_next;
  logic [pw-1:0] level_q;
  logic          empty_q;
  logic          almost_empty_q;
  logic          underflow_q;
  logic          pop;

`ifdef READ_PTR_SYNC_EN
  logic [pw-1:0] write_sync_q1;
  logic [pw-1:0] write_sync_q2;

  always_ff @(posedge read_clock_i or posedge read_reset_i) begin
    if (read_reset_i) begin
      write_sync_q1 <= '0;
      write_sync_q2 <= '0;
    end else begin
      write_sync_q1 <= bus.write_to_read_pointer_i;
      write_sync_q2 <= write_sync_q1;
    end
  end

  assign write_gray = write_sync_q2;
`else
  assign write_gray = bus.write_to_read_pointer_i;
`endif

  gray_to_binary #(.width(pw)) u_write_g2b (
    .gray_i   (write_gray),
    .binary_o (write_binary)
  );

  // Flags are computed from the post-pop pointer so the last pop raises empty on its own edge.
  assign pop              = bus.read_inc_i & ~empty_q;
  assign read_binary_next = read_binary_q + {{(pw-1){1'b0}}, pop};
  assign read_gray_next   = pw'(bin2gray(32'(read_binary_next)));
  assign level_next       = write_binary - read_binary_next;

  always_ff @(posedge read_clock_i or posedge read_reset_i) begin
    if (read_reset_i) begin
      read_binary_q  <= '0;
      read_gray_q    <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      read_binary_q  <= read_binary_next;
      read_gray_q    <= read_gray_next;
      level_q        <= level_next;
      empty_q        <= (write_gray == read_gray_next);
      almost_empty_q <= (level_next <= bus.almost_empty_threshold_i);
      if (bus.read_inc_i && empty_q) begin
        underflow_q <= 1'b1;
      end else if (bus.read_underflow_clear_i) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.read_address_o      = read_binary_q[addr_size-1:0];
  assign bus.read_pointer_o      = read_gray_q;
  assign bus.read_level_o        = level_q;
  assign bus.read_empty_o        = empty_q;
  assign bus.read_almost_empty_o = almost_empty_q;
  assign bus.read_underflow_o    = underflow_q;

endmodule

// File: tb/tb_read_level_block.sv
// tb/tb_read_level_block.sv - scoreboard testbench for read_level_block
module tb_read_level_block;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  read_level_block_if #(.addr_size(3)) bus ();

  read_level_block #(.addr_size(3)) dut (
    .read_clock_i (clk),
    .read_reset_i (rst),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: counts of words written/read and the current registered flags.
  int          m_wr;
  int          m_rd;
  int          m_thr;
  logic        m_empty;
  logic        m_uf;
  logic [14:0] sb[$];

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [14:0] observed();
    return {bus.read_address_o, bus.read_pointer_o, bus.read_level_o,
            bus.read_empty_o, bus.read_almost_empty_o, bus.read_underflow_o};
  endfunction

  task automatic model_reset();
    m_rd    = 0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
  endtask

  // Drives one cycle of stimulus, advances the model and queues the expected post-edge outputs.
  task automatic step(input logic inc, input logic clr);
    int         lvl;
    logic       pop;
    logic       alm;
    logic [3:0] rd4;
    logic [3:0] lv4;
    @(negedge clk);
    bus.read_inc_i               = inc;
    bus.read_underflow_clear_i   = clr;
    bus.write_to_read_pointer_i  = to_gray(m_wr);
    bus.almost_empty_threshold_i = 4'(m_thr);
    pop = inc && !m_empty;
    if (inc && m_empty) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    m_rd    = (m_rd + (pop ? 1 : 0)) % 16;
    lvl     = (m_wr - m_rd + 16) % 16;
    m_empty = (lvl == 0);
    alm     = (lvl <= m_thr);
    rd4     = m_rd[3:0];
    lv4     = lvl[3:0];
    sb.push_back({rd4[2:0], to_gray(m_rd), lv4, m_empty, alm, m_uf});
    @(posedge clk);
    #2;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      logic [14:0] exp;
      logic [14:0] got;
      exp = sb.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t got addr=%0d ptr=%h lvl=%0d e=%b ae=%b uf=%b expected addr=%0d ptr=%h lvl=%0d e=%b ae=%b uf=%b",
                 $time, got[14:12], got[11:8], got[7:4], got[3], got[2], got[1],
                 exp[14:12], exp[11:8], exp[7:4], exp[3], exp[2], exp[1]);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    m_wr = 0;
    m_thr = 1;
    bus.read_inc_i = 1'b0;
    bus.read_underflow_clear_i = 1'b0;
    bus.write_to_read_pointer_i = '0;
    bus.almost_empty_threshold_i = 4'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 15'b000_0000_0000_110) begin
      errors++;
      $display("FAIL reset_values got %h expected %h", observed(), 15'b000_0000_0000_110);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    m_wr = 4;
    m_thr = 1;
    step(1'b0, 1'b0);
    checks++;
    if (bus.read_level_o !== 4'd4 || bus.read_empty_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_level got %0d/%b expected 4/0", bus.read_level_o, bus.read_empty_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.read_address_o !== 3'(i)) begin
        errors++;
        $display("FAIL drain_addr got %0d expected %0d", bus.read_address_o, i);
      end
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b0);
    checks++;
    if (bus.read_pointer_o !== 4'd6 || bus.read_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_last got ptr=%h e=%b expected ptr=6 e=1", bus.read_pointer_o, bus.read_empty_o);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (bus.read_pointer_o !== 4'd6 || bus.read_underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set got ptr=%h uf=%b expected ptr=6 uf=1", bus.read_pointer_o, bus.read_underflow_o);
    end
    step(1'b1, 1'b1);
    checks++;
    if (bus.read_underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set_wins got %b expected 1", bus.read_underflow_o);
    end
    step(1'b0, 1'b1);
    checks++;
    if (bus.read_underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear got %b expected 0", bus.read_underflow_o);
    end
  endtask

  task automatic test_full_wrap();
    m_wr = 12;
    step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);
    m_wr = 20 % 16;
    step(1'b0, 1'b0);
    checks++;
    if (bus.read_level_o !== 4'd8 || bus.read_empty_o !== 1'b0) begin
      errors++;
      $display("FAIL full_level got %0d/%b expected 8/0", bus.read_level_o, bus.read_empty_o);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.read_address_o !== 3'((i + 4) % 8)) begin
        errors++;
        $display("FAIL wrap_addr got %0d expected %0d", bus.read_address_o, (i + 4) % 8);
      end
      step(1'b1, 1'b0);
    end
    checks++;
    if (bus.read_pointer_o !== 4'd6 || bus.read_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end got ptr=%h e=%b expected ptr=6 e=1", bus.read_pointer_o, bus.read_empty_o);
    end
  endtask

  task automatic test_threshold_sweep();
    m_wr = 9;
    step(1'b0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      m_thr = t;
      step(1'b0, 1'b0);
      checks++;
      if (bus.read_almost_empty_o !== (t >= 5)) begin
        errors++;
        $display("FAIL threshold_%0d got %b expected %b", t, bus.read_almost_empty_o, (t >= 5));
      end
    end
  endtask

  task automatic test_mid_reset();
    m_thr = 1;
    repeat (2) step(1'b1, 1'b0);
    checks++;
    if (bus.read_level_o !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_level got %0d expected 3", bus.read_level_o);
    end
    @(negedge clk);
    bus.read_inc_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (observed() !== 15'b000_0000_0000_110) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", observed(), 15'b000_0000_0000_110);
    end
    m_wr = 0;
    bus.write_to_read_pointer_i = '0;
    bus.read_inc_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_full_wrap();
    test_threshold_sweep();
    test_mid_reset();
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_level_block.md
Name: read_level_block

Overview:
Parametrised next-generation read-side controller for the asynchronous FIFO in the i2c_fifo_block.
- Keeps the read binary/gray pointers and the read address, plus registered empty and almost-empty flags.
- Adds a fill-level output, a programmable almost-empty threshold, and a sticky underflow flag.
- Sits in the read domain, next to the dual-port memory. It takes the write pointer as gray code that has already been brought into the read domain, unless the optional internal synchroniser is enabled.

Parameters:
addr_size, 3, memory address width; FIFO depth DEPTH = 2**addr_size; pointers are addr_size+1 bits.

Ports:
read_clock_i  in  1  read-domain clock; all state on rising edge.
read_reset_i  in  1  asynchronous, active-high reset.
read_inc_i  in  1  pop request.
write_to_read_pointer_i  in  addr_size+1  write pointer, gray code.
almost_empty_threshold_i  in  addr_size+1  almost-empty level, quasi-static.
read_underflow_clear_i  in  1  clears the sticky underflow flag.
read_address_o  out  addr_size  memory read address = read_binary[addr_size-1:0].
read_pointer_o  out  addr_size+1  registered gray read pointer, sent to the write domain.
read_level_o  out  addr_size+1  registered words available, 0..DEPTH.
read_empty_o  out  1  FIFO empty.
read_almost_empty_o  out  1  level <= threshold.
read_underflow_o  out  1  sticky: a pop was attempted while empty.

Behaviour:
- One clock; reset is asynchronous and active-high (read_clock_i, read_reset_i).
- Reset values:
  - read_binary = 0, read_pointer_o = 0, read_address_o = 0.
  - read_level_o = 0, read_empty_o = 1, read_almost_empty_o = 1, read_underflow_o = 0.
  - Reset asserted mid-stream clears everything immediately, with no completion of any pending pop.
- Pointer update:
  - pop = read_inc_i & ~read_empty_o.
  - read_binary_next = read_binary + pop, modulo 2**(addr_size+1).
  - read_gray_next = (read_binary_next >> 1) ^ read_binary_next.
  - Both pointers are registered on every edge.
- Level computation:
  - wbin = gray-to-binary of the (optionally synchronised) write pointer.
  - level_next = wbin - read_binary_next, modulo 2**(addr_size+1); registered into read_level_o.
- Flags, registered from the _next values (one cycle latency from an input change):
  - read_empty_o = (write gray == read_gray_next).
  - read_almost_empty_o = (level_next <= almost_empty_threshold_i). It is therefore also high when empty.
  - Threshold 0 makes almost-empty equal to empty.
- Pop and flag update on the same edge:
  - A pop that takes the last word asserts read_empty_o on that same edge.
  - A pop attempted while read_empty_o = 1 leaves the pointers unchanged.
- Underflow flag:
  - Sets when read_inc_i & read_empty_o at an edge.
  - Clears when read_underflow_clear_i is high.
  - Set and clear on the same edge: set wins.
- Wrap-around: pointers wrap naturally through 2**(addr_size+1). Level and empty stay correct across the wrap; full FIFO reads level = DEPTH.
- A write pointer that moves by more than one gray step per cycle is tolerated only when it is consistent with a monotonically advancing writer. level_next > DEPTH is illegal and is not checked.

Optional Feature:
READ_PTR_SYNC_EN
- Defined: write_to_read_pointer_i passes through an internal two-flop synchroniser, reset to 0 by read_reset_i, before any use. Level and flags lag the input by 3 cycles.
- Undefined: the input is used directly, with 1 cycle flag latency; the synchroniser lives outside the block.

Decomposition:
- Shared package fifo_pkg holds:
  - constants DEPTH and PTR_W = addr_size+1;
  - functions bin2gray and gray2bin, which the write-side block will also use.
- One natural sub-module, gray_to_binary: a parametrised width XOR-prefix converter, instantiated for the write-pointer conversion.

Test Plan:
(addr_size = 3, macro undefined)
- Reset: assert read_reset_i with write pointer 0 -> empty=1, almost=1, level=0, addr=0, pointer=0. Deassert with no writes -> all unchanged.
- Fill and drain: write pointer = gray(4) = 6, threshold = 1 -> next cycle empty=0, level=4, almost=0. Pop 3 times -> addr 0,1,2 consumed, level=1, almost=1, empty=0. Fourth pop -> empty=1, level=0, pointer = gray(4) = 6.
- Underflow: with empty=1, hold read_inc_i for 2 cycles -> pointer unchanged, underflow=1 from the next edge. Pulse clear together with another read_inc_i -> underflow stays 1. Clear alone -> underflow=0.
- Full and wrap: read pointer at binary 12, write pointer = gray(20 mod 16 = 4) = 6 -> level=8, empty=0. Pop 8 times -> addresses 4,5,6,7,0,1,2,3, then empty=1, pointer = gray(4) = 6.
- Threshold sweep: level=5, threshold varied 0 to 7 -> almost goes high once threshold >= 5, one cycle after the change.
- Mid-operation reset: with level=3 and read_inc_i high, assert read_reset_i between edges -> outputs return to reset values immediately, asynchronously.
